// File: rtl/alu_pkg.sv
// alu_pkg: flag bit indices, branch condition codes and the condition evaluator
package alu_pkg;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [2:0] BR_AL = 3'b000;
  localparam logic [2:0] BR_EQ = 3'b001;
  localparam logic [2:0] BR_NE = 3'b010;
  localparam logic [2:0] BR_LT = 3'b011;
  localparam logic [2:0] BR_GE = 3'b100;
  localparam logic [2:0] BR_CS = 3'b101;
  localparam logic [2:0] BR_CC = 3'b110;
  localparam logic [2:0] BR_VS = 3'b111;
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] f);
    logic lt;
    logic [7:0] t;
    lt = f[FLAG_S] ^ f[FLAG_V];
    t  = {f[FLAG_V], ~f[FLAG_C], f[FLAG_C], ~lt, lt, ~f[FLAG_Z], f[FLAG_Z], 1'b1};
    return t[cc];
  endfunction
endpackage

// File: rtl/wb_skid_buffer.sv
// wb_skid_buffer: generic 2-entry valid/ready buffer (main + skid register)
module wb_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         accept, emit, main_load;
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = main_valid_q & out_ready_i;
  // next state: main refills from skid when it drains, otherwise from the input
  always_comb begin
    main_load    = main_valid_q ? (emit & (skid_valid_q | accept)) : accept;
    main_valid_d = skid_valid_q | accept | (main_valid_q & ~emit);
    skid_valid_d = skid_valid_q ? ~emit : (main_valid_q & accept & ~emit);
    main_d       = main_load ? (skid_valid_q ? skid_q : in_data_i) : main_q;
    skid_d       = (~skid_valid_q & main_valid_q & accept & ~emit) ? in_data_i : skid_q;
  end
  // buffer registers, cleared asynchronously so reset drops any buffered beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end
endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: ALU result capture, flag commit, branch resolve, skid-buffered writeback (option: WB_STAGE_PERF_CNT_EN)
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
`ifdef WB_STAGE_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [DW-1:0]    ALU_OUT,
  input  logic [3:0]       FLAG_OUT,
  input  logic             FLAG_WE,
  input  logic [AW-1:0]    RD_ADDR,
  input  logic             RD_WE,
  input  logic             BR_EN,
  input  logic [2:0]       BR_COND,
  output logic             WB_VALID,
  input  logic             WB_READY,
  output logic [DW-1:0]    WB_DATA,
  output logic [AW-1:0]    WB_ADDR,
  output logic             WB_WE,
  output logic             BR_TAKEN,
`ifdef WB_STAGE_PERF_CNT_EN
  output logic [CNT_W-1:0] PERF_OPS,
  output logic [CNT_W-1:0] PERF_BR,
`endif
  output logic [3:0]       FLAGS
);
  localparam int PW = DW + AW + 2;
  logic [3:0]    flags_q, flags_d;
  logic          accept, br_taken;
  logic [PW-1:0] out_payload;
  assign accept   = IN_VALID & IN_READY;
  assign br_taken = BR_EN & cond_eval(BR_COND, flags_q);
  assign FLAGS    = flags_q;
  assign {WB_DATA, WB_ADDR, WB_WE, BR_TAKEN} = out_payload;
  wb_skid_buffer #(.W(PW)) u_skid (
    .clk         (CLK),
    .rst_n       (RST_N),
    .in_valid_i  (IN_VALID),
    .in_ready_o  (IN_READY),
    .in_data_i   ({ALU_OUT, RD_ADDR, RD_WE, br_taken}),
    .out_valid_o (WB_VALID),
    .out_ready_i (WB_READY),
    .out_data_o  (out_payload)
  );
  // flags commit at accept; the branch above sees the pre-update value
  always_comb flags_d = (accept & FLAG_WE) ? FLAG_OUT : flags_q;
  // architectural flag register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end
`ifdef WB_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_ops_q, perf_ops_d, perf_br_q, perf_br_d;
  assign PERF_OPS = perf_ops_q;
  assign PERF_BR  = perf_br_q;
  // counters wrap naturally at all-ones
  always_comb begin
    perf_ops_d = accept ? perf_ops_q + 1'b1 : perf_ops_q;
    perf_br_d  = (accept & br_taken) ? perf_br_q + 1'b1 : perf_br_q;
  end
  // accepted-op and taken-branch counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_ops_q <= '0;
      perf_br_q  <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_br_q  <= perf_br_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed self-checking bench for alu_writeback_stage
module tb_alu_writeback_stage;
  import alu_pkg::*;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        IN_VALID = 1'b0, IN_READY;
  logic [15:0] ALU_OUT = '0;
  logic [3:0]  FLAG_OUT = '0;
  logic        FLAG_WE = 1'b0;
  logic [2:0]  RD_ADDR = '0;
  logic        RD_WE = 1'b0, BR_EN = 1'b0;
  logic [2:0]  BR_COND = '0;
  logic        WB_VALID, WB_READY = 1'b1;
  logic [15:0] WB_DATA;
  logic [2:0]  WB_ADDR;
  logic        WB_WE, BR_TAKEN;
  logic [3:0]  FLAGS;
`ifdef WB_STAGE_PERF_CNT_EN
  logic [15:0] PERF_OPS, PERF_BR;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 CLK = ~CLK;
  alu_writeback_stage dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .FLAG_OUT(FLAG_OUT), .FLAG_WE(FLAG_WE), .RD_ADDR(RD_ADDR),
    .RD_WE(RD_WE), .BR_EN(BR_EN), .BR_COND(BR_COND), .WB_VALID(WB_VALID),
    .WB_READY(WB_READY), .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .WB_WE(WB_WE),
    .BR_TAKEN(BR_TAKEN),
`ifdef WB_STAGE_PERF_CNT_EN
    .PERF_OPS(PERF_OPS), .PERF_BR(PERF_BR),
`endif
    .FLAGS(FLAGS)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic send(input logic [15:0] d, input logic [2:0] a, input logic we,
                      input logic fwe, input logic [3:0] fo, input logic be, input logic [2:0] cc);
    IN_VALID = 1'b1; ALU_OUT = d; RD_ADDR = a; RD_WE = we;
    FLAG_WE = fwe; FLAG_OUT = fo; BR_EN = be; BR_COND = cc;
    @(negedge CLK);
  endtask
  task automatic idle();
    IN_VALID = 1'b0; FLAG_WE = 1'b0; BR_EN = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_wb_valid", WB_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_flags", FLAGS, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    // streaming
    WB_READY = 1'b1;
    send(16'h1234, 3'd1, 1, 0, 4'h0, 0, BR_AL);
    check("stream_d0", WB_DATA, 16'h1234);
    check("stream_v0", WB_VALID, 1);
    send(16'h5678, 3'd2, 1, 0, 4'h0, 0, BR_AL);
    check("stream_d1", WB_DATA, 16'h5678);
    check("stream_rdy1", IN_READY, 1);
    send(16'h9ABC, 3'd3, 1, 0, 4'h0, 0, BR_AL);
    check("stream_d2", WB_DATA, 16'h9ABC);
    check("stream_addr2", WB_ADDR, 3);
    idle();
    @(negedge CLK);
    check("stream_drain", WB_VALID, 0);
    // backpressure
    WB_READY = 1'b0;
    send(16'h0001, 3'd4, 1, 0, 4'h0, 0, BR_AL);
    check("bp_rdy_one", IN_READY, 1);
    check("bp_d_one", WB_DATA, 16'h0001);
    send(16'h0002, 3'd5, 1, 0, 4'h0, 0, BR_AL);
    check("bp_rdy_full", IN_READY, 0);
    check("bp_d_full", WB_DATA, 16'h0001);
    idle();
    @(negedge CLK);
    check("bp_stable", WB_DATA, 16'h0001);
    check("bp_stable_v", WB_VALID, 1);
    WB_READY = 1'b1;
    @(negedge CLK);
    check("bp_second", WB_DATA, 16'h0002);
    check("bp_second_addr", WB_ADDR, 5);
    check("bp_rdy_back", IN_READY, 1);
    @(negedge CLK);
    check("bp_empty", WB_VALID, 0);
    // flag/branch ordering
    send(16'h0, 3'd0, 0, 1, 4'b0100, 0, BR_AL);
    send(16'h0, 3'd0, 0, 0, 4'b0000, 1, BR_EQ);
    check("order_b_taken", BR_TAKEN, 1);
    check("order_flags", FLAGS, 4'b0100);
    send(16'h0, 3'd0, 0, 1, 4'b0000, 0, BR_AL);
    check("order_clear", FLAGS, 0);
    send(16'h0, 3'd0, 0, 1, 4'b0100, 1, BR_EQ);
    check("same_beat_taken", BR_TAKEN, 0);
    check("same_beat_flags", FLAGS, 4'b0100);
    // condition sweep and RD_WE=0 passthrough
    send(16'hBEEF, 3'd6, 0, 1, 4'b1000, 0, BR_AL);
    check("nowe_we", WB_WE, 0);
    check("nowe_data", WB_DATA, 16'hBEEF);
    check("nowe_valid", WB_VALID, 1);
    send(16'h0, 3'd0, 1, 0, 4'h0, 1, BR_LT);
    check("lt_s1v0", BR_TAKEN, 1);
    check("we_on", WB_WE, 1);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_GE);
    check("ge_s1v0", BR_TAKEN, 0);
    send(16'h0, 3'd0, 0, 1, 4'b1001, 0, BR_AL);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_LT);
    check("lt_s1v1", BR_TAKEN, 0);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_GE);
    check("ge_s1v1", BR_TAKEN, 1);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_VS);
    check("vs_v1", BR_TAKEN, 1);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_NE);
    check("ne_z0", BR_TAKEN, 1);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_CS);
    check("cs_c0", BR_TAKEN, 0);
    send(16'h0, 3'd0, 0, 0, 4'h0, 1, BR_CC);
    check("cc_c0", BR_TAKEN, 1);
    send(16'h0, 3'd0, 0, 0, 4'h0, 0, BR_AL);
    check("al_no_en", BR_TAKEN, 0);
    // reset with a full buffer
    WB_READY = 1'b0;
    send(16'hAAAA, 3'd1, 1, 0, 4'h0, 0, BR_AL);
    send(16'hBBBB, 3'd2, 1, 0, 4'h0, 0, BR_AL);
    check("pre_rst_full", IN_READY, 0);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_valid", WB_VALID, 0);
    check("mid_rst_flags", FLAGS, 0);
    check("mid_rst_ready", IN_READY, 1);
    check("mid_rst_data", WB_DATA, 0);
    @(negedge CLK);
    check("rst_no_accept", WB_VALID, 0);
    idle();
    RST_N = 1'b1;
    WB_READY = 1'b1;
    @(negedge CLK);
    check("post_rst_empty", WB_VALID, 0);
`ifdef WB_STAGE_PERF_CNT_EN
    check("perf_ops_rst", PERF_OPS, 0);
    for (int i = 0; i < 3; i++) send(16'(i), 3'd0, 1, 0, 4'h0, 1, BR_AL);
    check("perf_br3", PERF_BR, 3);
    check("perf_ops3", PERF_OPS, 3);
    for (int i = 0; i < 65532; i++) send(16'(i), 3'd0, 1, 0, 4'h0, 0, BR_AL);
    check("perf_ops_max", PERF_OPS, 16'hFFFF);
    send(16'h0, 3'd0, 1, 0, 4'h0, 0, BR_AL);
    check("perf_ops_wrap", PERF_OPS, 0);
    check("perf_br_hold", PERF_BR, 3);
    idle();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
